regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter.
// Two requesters (ALU "A" and load "L") each feed a small FIFO of
// {reg, data} writes. One FIFO head per cycle is granted round-robin and
// loaded into a registered write port. An outstanding-write mask (Pending)
// and a read-after-write Stall are derived from the queued entries and the
// active output stage.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        A_Valid,
  output logic        A_Ready,
  input  logic [4:0]  A_Reg,
  input  logic [31:0] A_Data,
  input  logic        L_Valid,
  output logic        L_Ready,
  input  logic [4:0]  L_Reg,
  input  logic [31:0] L_Data,
  input  logic        Flush,
  output logic        Reg_Write,
  output logic [4:0]  Write_Reg,
  output logic [31:0] Write_Data,
  input  logic [4:0]  Read_Reg_1,
  input  logic [4:0]  Read_Reg_2,
  output logic [31:0] Pending,
  output logic        Stall
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Index 0 is the A (ALU) queue, index 1 is the L (load) queue.
  logic [4:0]    reg_mem_r  [2][FIFO_DEPTH];
  logic [31:0]   data_mem_r [2][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r   [2];
  logic [PW-1:0] rd_ptr_r   [2];
  logic [CW-1:0] count_r    [2];
  // Round-robin priority: 0 favours A, 1 favours L.
  logic          prio_r;

  logic [1:0]    in_valid_s;
  logic [4:0]    in_reg_s   [2];
  logic [31:0]   in_data_s  [2];
  logic [1:0]    ready_s;
  logic [1:0]    push_s;
  logic [1:0]    nonempty_s;
  logic [1:0]    grant_s;
  logic [4:0]    head_reg_s;
  logic [31:0]   head_data_s;
  logic [PW-1:0] offset_s;
  logic [31:0]   pending_s;
  logic          stall_s;

  // Decoded one-hot mask for a register index.
  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    reg_onehot = 32'd1 << r;
  endfunction

  assign in_valid_s   = {L_Valid, A_Valid};
  assign in_reg_s[0]  = A_Reg;
  assign in_reg_s[1]  = L_Reg;
  assign in_data_s[0] = A_Data;
  assign in_data_s[1] = L_Data;

  // Handshake: ready only out of reset, not flushing and with free space
  // (a full queue never takes a push even when it pops this cycle).
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      nonempty_s[q] = (count_r[q] != {CW{1'b0}});
      ready_s[q]    = rst & ~Flush & (count_r[q] < DEPTH_C);
      push_s[q]     = in_valid_s[q] & ready_s[q];
    end
  end

  assign A_Ready = ready_s[0];
  assign L_Ready = ready_s[1];

  // Round-robin grant of a single FIFO head; nothing granted during flush or reset.
  always_comb begin
    grant_s = 2'b00;
    if (rst && !Flush) begin
      if (nonempty_s[0] && (!nonempty_s[1] || (prio_r == 1'b0))) begin
        grant_s = 2'b01;
      end else if (nonempty_s[1]) begin
        grant_s = 2'b10;
      end else begin
        grant_s = 2'b00;
      end
    end else begin
      grant_s = 2'b00;
    end
  end

  // Select the head entry of whichever queue is granted.
  always_comb begin
    head_reg_s  = 5'd0;
    head_data_s = 32'd0;
    if (grant_s[1]) begin
      head_reg_s  = reg_mem_r[1][rd_ptr_r[1]];
      head_data_s = data_mem_r[1][rd_ptr_r[1]];
    end else begin
      head_reg_s  = reg_mem_r[0][rd_ptr_r[0]];
      head_data_s = data_mem_r[0][rd_ptr_r[0]];
    end
  end

  // Queue storage: entries are only meaningful inside the occupancy window.
  always_ff @(posedge clk) begin
    for (int q = 0; q < 2; q++) begin
      if (push_s[q]) begin
        reg_mem_r[q][wr_ptr_r[q]]  <= in_reg_s[q];
        data_mem_r[q][wr_ptr_r[q]] <= in_data_s[q];
      end
    end
  end

  // Queue pointers/occupancy, priority bit and registered write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int q = 0; q < 2; q++) begin
        wr_ptr_r[q] <= {PW{1'b0}};
        rd_ptr_r[q] <= {PW{1'b0}};
        count_r[q]  <= {CW{1'b0}};
      end
      prio_r     <= 1'b0;
      Reg_Write  <= 1'b0;
      Write_Reg  <= 5'd0;
      Write_Data <= 32'd0;
    end else if (Flush) begin
      for (int q = 0; q < 2; q++) begin
        wr_ptr_r[q] <= {PW{1'b0}};
        rd_ptr_r[q] <= {PW{1'b0}};
        count_r[q]  <= {CW{1'b0}};
      end
      Reg_Write <= 1'b0;
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (push_s[q]) begin
          wr_ptr_r[q] <= wr_ptr_r[q] + {{(PW-1){1'b0}}, 1'b1};
        end
        if (grant_s[q]) begin
          rd_ptr_r[q] <= rd_ptr_r[q] + {{(PW-1){1'b0}}, 1'b1};
        end
        count_r[q] <= count_r[q] + {{(CW-1){1'b0}}, push_s[q]}
                                 - {{(CW-1){1'b0}}, grant_s[q]};
      end
      if (grant_s != 2'b00) begin
        // Priority passes to the requester that was not served.
        prio_r <= grant_s[0];
        // Writes to r0 are consumed silently; the port keeps its last value.
        if (head_reg_s != 5'd0) begin
          Reg_Write  <= 1'b1;
          Write_Reg  <= head_reg_s;
          Write_Data <= head_data_s;
        end else begin
          Reg_Write  <= 1'b0;
        end
      end else begin
        Reg_Write <= 1'b0;
      end
    end
  end

  // Outstanding-write mask over all live queue entries plus the active port.
  always_comb begin
    pending_s = 32'd0;
    offset_s  = {PW{1'b0}};
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        offset_s = PW'(i) - rd_ptr_r[q];
        if ({1'b0, offset_s} < count_r[q]) begin
          pending_s = pending_s | reg_onehot(reg_mem_r[q][i]);
        end else begin
          pending_s = pending_s;
        end
      end
    end
    if (Reg_Write) begin
      pending_s = pending_s | reg_onehot(Write_Reg);
    end else begin
      pending_s = pending_s;
    end
    pending_s[0] = 1'b0;
  end

  // Read-after-write hazard against either decode source register.
  always_comb begin
    stall_s = ((Read_Reg_1 != 5'd0) && pending_s[Read_Reg_1]) ||
              ((Read_Reg_2 != 5'd0) && pending_s[Read_Reg_2]);
  end

  assign Pending = pending_s;
  assign Stall   = stall_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a queue-based reference
// model is compared with the DUT on every falling edge, and directed
// scenarios add hand-computed literal expectations.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        A_Valid = 1'b0;
  logic        A_Ready;
  logic [4:0]  A_Reg = 5'd0;
  logic [31:0] A_Data = 32'd0;
  logic        L_Valid = 1'b0;
  logic        L_Ready;
  logic [4:0]  L_Reg = 5'd0;
  logic [31:0] L_Data = 32'd0;
  logic        Flush = 1'b0;
  logic        Reg_Write;
  logic [4:0]  Write_Reg;
  logic [31:0] Write_Data;
  logic [4:0]  Read_Reg_1 = 5'd0;
  logic [4:0]  Read_Reg_2 = 5'd0;
  logic [31:0] Pending;
  logic        Stall;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  regfile_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Reg(A_Reg), .A_Data(A_Data),
    .L_Valid(L_Valid), .L_Ready(L_Ready), .L_Reg(L_Reg), .L_Data(L_Data),
    .Flush(Flush),
    .Reg_Write(Reg_Write), .Write_Reg(Write_Reg), .Write_Data(Write_Data),
    .Read_Reg_1(Read_Reg_1), .Read_Reg_2(Read_Reg_2),
    .Pending(Pending), .Stall(Stall)
  );

  always #5 clk = ~clk;

  // Reference model state: queued writes per requester, priority, write port.
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        m_aq[$];
  ent_t        m_lq[$];
  bit          m_prio = 1'b0;   // 0: A preferred
  logic        m_rw = 1'b0;
  logic [4:0]  m_wr = 5'd0;
  logic [31:0] m_wd = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = 32'd0;
    foreach (m_aq[i]) p[m_aq[i].r] = 1'b1;
    foreach (m_lq[i]) p[m_lq[i].r] = 1'b1;
    if (m_rw) p[m_wr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Model advance on each rising edge, from the inputs held over that edge.
  initial begin
    ent_t e;
    int   g;
    bit   ap;
    bit   lp;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_aq.delete(); m_lq.delete();
        m_prio = 1'b0; m_rw = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
      end else if (Flush) begin
        m_aq.delete(); m_lq.delete();
        m_rw = 1'b0;
      end else begin
        ap = A_Valid && (m_aq.size() < DEPTH);
        lp = L_Valid && (m_lq.size() < DEPTH);
        g = 0;
        if (m_aq.size() > 0 && (m_lq.size() == 0 || !m_prio)) g = 1;
        else if (m_lq.size() > 0) g = 2;
        e = '0;
        if (g == 1) e = m_aq.pop_front();
        if (g == 2) e = m_lq.pop_front();
        if (ap) m_aq.push_back({A_Reg, A_Data});
        if (lp) m_lq.push_back({L_Reg, L_Data});
        if (g != 0) begin
          m_prio = (g == 1);
          m_rw = (e.r != 5'd0);
          if (e.r != 5'd0) begin
            m_wr = e.r;
            m_wd = e.d;
          end
        end else begin
          m_rw = 1'b0;
        end
      end
    end
  end

  // Compare process: every falling edge once the DUT has seen a reset edge.
  always @(negedge clk) begin
    logic [31:0] mp;
    if (cmp_en) begin
      mp = model_pending();
      chk("cyc_reg_write",  {31'd0, Reg_Write}, {31'd0, m_rw});
      chk("cyc_write_reg",  {27'd0, Write_Reg}, {27'd0, m_wr});
      chk("cyc_write_data", Write_Data, m_wd);
      chk("cyc_a_ready", {31'd0, A_Ready},
          {31'd0, rst && !Flush && (m_aq.size() < DEPTH)});
      chk("cyc_l_ready", {31'd0, L_Ready},
          {31'd0, rst && !Flush && (m_lq.size() < DEPTH)});
      chk("cyc_pending", Pending, mp);
      chk("cyc_stall", {31'd0, Stall},
          {31'd0, ((Read_Reg_1 != 5'd0) && mp[Read_Reg_1]) ||
                  ((Read_Reg_2 != 5'd0) && mp[Read_Reg_2])});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    cmp_en = 1'b1;
    tick();
    #1;
    chk("rst_reg_write", {31'd0, Reg_Write}, 32'd0);
    chk("rst_write_reg", {27'd0, Write_Reg}, 32'd0);
    chk("rst_write_data", Write_Data, 32'd0);
    chk("rst_pending", Pending, 32'd0);
    chk("rst_a_ready", {31'd0, A_Ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_a_ready", {31'd0, A_Ready}, 32'd1);

    // Single push of r5 and its timing
    tick();
    A_Valid = 1'b1; A_Reg = 5'd5; A_Data = 32'h0000_00AA;
    Read_Reg_2 = 5'd5;
    tick();                               // edge N: push
    A_Valid = 1'b0;
    #1;
    chk("single_pending_q", Pending, 32'h0000_0020);
    chk("single_stall_q", {31'd0, Stall}, 32'd1);
    chk("single_rw_early", {31'd0, Reg_Write}, 32'd0);
    tick();                               // edge N+1: grant
    #1;
    chk("single_rw", {31'd0, Reg_Write}, 32'd1);
    chk("single_wreg", {27'd0, Write_Reg}, 32'd5);
    chk("single_wdata", Write_Data, 32'h0000_00AA);
    chk("single_pending_out", Pending, 32'h0000_0020);
    tick();                               // edge N+2: committed
    #1;
    chk("single_rw_done", {31'd0, Reg_Write}, 32'd0);
    chk("single_pending_clr", Pending, 32'd0);
    chk("single_wreg_hold", {27'd0, Write_Reg}, 32'd5);
    Read_Reg_2 = 5'd0;

    // Both requesters push every cycle: alternating 1,2 with A first
    do_reset();
    Read_Reg_2 = 5'd2;
    A_Valid = 1'b1; A_Reg = 5'd1; A_Data = 32'hA0A0_0001;
    L_Valid = 1'b1; L_Reg = 5'd2; L_Data = 32'hB0B0_0002;
    for (int i = 0; i < 12; i++) begin
      tick();
      #1;
      if (i == 1) chk("rr_first_A", {27'd0, Write_Reg}, 32'd1);
      if (i == 2) chk("rr_second_L", {27'd0, Write_Reg}, 32'd2);
      if (i == 3) chk("rr_third_A", {27'd0, Write_Reg}, 32'd1);
    end
    A_Valid = 1'b0; L_Valid = 1'b0; Read_Reg_2 = 5'd0;
    for (int i = 0; i < 6; i++) tick();

    // Fill A while L holds priority and is non-empty
    do_reset();
    A_Valid = 1'b1; A_Reg = 5'd3; A_Data = 32'h0000_0003;
    tick();
    A_Valid = 1'b0;
    tick();                               // A granted -> priority to L
    tick();
    A_Valid = 1'b1; A_Reg = 5'd10; A_Data = 32'h0000_0010;
    L_Valid = 1'b1; L_Reg = 5'd20; L_Data = 32'h0000_0020;
    tick();                               // e0
    A_Reg = 5'd11; A_Data = 32'h0000_0011;
    L_Reg = 5'd21; L_Data = 32'h0000_0021;
    tick();                               // e1: L20 granted
    L_Valid = 1'b0;
    A_Reg = 5'd12; A_Data = 32'h0000_0012;
    #1;
    chk("fill_a_full", {31'd0, A_Ready}, 32'd0);
    chk("fill_wreg_20", {27'd0, Write_Reg}, 32'd20);
    tick();                               // e2: A10 granted, A12 refused
    #1;
    chk("fill_wreg_10", {27'd0, Write_Reg}, 32'd10);
    chk("fill_a_ready", {31'd0, A_Ready}, 32'd1);
    tick();                               // e3: L21 granted, A12 pushed
    A_Valid = 1'b0;
    #1;
    chk("fill_wreg_21", {27'd0, Write_Reg}, 32'd21);
    tick();                               // e4
    #1;
    chk("fill_wreg_11", {27'd0, Write_Reg}, 32'd11);
    tick();                               // e5
    #1;
    chk("fill_wreg_12", {27'd0, Write_Reg}, 32'd12);
    tick();

    // Write to r0 is consumed without a register-file write
    A_Valid = 1'b1; A_Reg = 5'd0; A_Data = 32'hFFFF_FFFF;
    tick();
    A_Valid = 1'b0;
    #1;
    chk("r0_pending_q", Pending, 32'd0);
    tick();
    #1;
    chk("r0_no_write", {31'd0, Reg_Write}, 32'd0);
    chk("r0_pending", Pending, 32'd0);
    tick();

    // Hazard then flush with a loaded output stage
    A_Valid = 1'b1; A_Reg = 5'd7; A_Data = 32'h0000_0707;
    L_Valid = 1'b1; L_Reg = 5'd9; L_Data = 32'h0000_0909;
    tick();
    A_Valid = 1'b0; L_Valid = 1'b0;
    Read_Reg_1 = 5'd7;
    #1;
    chk("haz_stall", {31'd0, Stall}, 32'd1);
    chk("haz_pending", Pending, 32'h0000_0280);
    tick();                               // one of them enters the port
    Flush = 1'b1;
    #1;
    chk("flush_a_ready", {31'd0, A_Ready}, 32'd0);
    chk("flush_loaded", {31'd0, Reg_Write}, 32'd1);
    tick();                               // flush edge
    Flush = 1'b0;
    #1;
    chk("flush_pending", Pending, 32'd0);
    chk("flush_stall", {31'd0, Stall}, 32'd0);
    chk("flush_no_write", {31'd0, Reg_Write}, 32'd0);
    Read_Reg_1 = 5'd0;
    tick();

    // Reset mid-operation
    A_Valid = 1'b1; A_Reg = 5'd4; A_Data = 32'h0000_0004;
    L_Valid = 1'b1; L_Reg = 5'd6; L_Data = 32'h0000_0006;
    tick();
    A_Reg = 5'd5; L_Reg = 5'd8;
    tick();
    A_Valid = 1'b0; L_Valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_a_ready", {31'd0, A_Ready}, 32'd0);
    chk("mid_rst_l_ready", {31'd0, L_Ready}, 32'd0);
    tick();
    #1;
    chk("mid_rst_rw", {31'd0, Reg_Write}, 32'd0);
    chk("mid_rst_pending", Pending, 32'd0);
    chk("mid_rst_wreg", {27'd0, Write_Reg}, 32'd0);
    rst = 1'b1;
    A_Valid = 1'b1; A_Reg = 5'd13; A_Data = 32'h0000_0013;
    L_Valid = 1'b1; L_Reg = 5'd14; L_Data = 32'h0000_0014;
    tick();
    A_Valid = 1'b0; L_Valid = 1'b0;
    tick();
    #1;
    chk("after_rst_A_first", {27'd0, Write_Reg}, 32'd13);
    tick();
    #1;
    chk("after_rst_L_next", {27'd0, Write_Reg}, 32'd14);
    tick();
    tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
